// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: C_NUM_REG 32-bit registers exposed on REG_OUT,
// with a one-cycle REG_WE pulse per committed write. Independent read and write
// channels, one outstanding transaction each, SLVERR on addresses outside the bank.
module axil_reg_bank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR = 32'h70E00000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR = 32'h70E0FFFF,
  parameter int C_NUM_REG          = 4,
  parameter bit C_USE_WSTRB        = 1'b1
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_NUM_REG*C_S_AXI_DATA_WIDTH-1:0] REG_OUT,
  output logic [C_NUM_REG-1:0]                   REG_WE
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = (C_NUM_REG > 1) ? $clog2(C_NUM_REG) : 1;
  // last byte address of the register window, one extra bit so it cannot wrap
  localparam logic [AW:0] LAST_HIT = {1'b0, C_BASEADDR} + (AW+1)'(4 * C_NUM_REG - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_GOT_A, W_GOT_W, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DW-1:0] regs [C_NUM_REG];

  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  // address is inside the bank and inside the block window
  function automatic logic is_hit(input logic [AW-1:0] a);
    return ({1'b0, a} >= {1'b0, C_BASEADDR}) && ({1'b0, a} <= LAST_HIT) &&
           (a <= C_HIGHADDR);
  endfunction

  // register index from the word offset; byte offset bits are ignored
  function automatic logic [IDX_W-1:0] to_idx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - C_BASEADDR;
    return IDX_W'(off >> 2);
  endfunction

  // byte-lane merge of new data over the old register value
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d,
                                          input logic [DW-1:0] new_d,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    for (int b = 0; b < SW; b++)
      r[8*b +: 8] = strb[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
    return r;
  endfunction

  // readiness follows the FSM state; reset forces every ready low
  assign S_AXI_AWREADY = !S_AXI_ARESET && (w_state == W_IDLE || w_state == W_GOT_W);
  assign S_AXI_WREADY  = !S_AXI_ARESET && (w_state == W_IDLE || w_state == W_GOT_A);
  assign S_AXI_ARREADY = !S_AXI_ARESET && (r_state == R_IDLE);

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // pick commit address/data from latched or live channel, depending on arrival order
  logic          commit;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  logic [SW-1:0] c_strb;
  always_comb begin
    commit = 1'b0;
    c_addr = S_AXI_AWADDR;
    c_data = S_AXI_WDATA;
    c_strb = S_AXI_WSTRB;
    case (w_state)
      W_IDLE:  commit = aw_hs && w_hs;
      W_GOT_A: begin
        commit = w_hs;
        c_addr = awaddr_q;
      end
      W_GOT_W: begin
        commit = aw_hs;
        c_data = wdata_q;
        c_strb = wstrb_q;
      end
      default: commit = 1'b0;
    endcase
  end

  logic             c_hit;
  logic [IDX_W-1:0] c_idx;
  logic [SW-1:0]    c_strb_eff;
  assign c_hit      = is_hit(c_addr);
  assign c_idx      = to_idx(c_addr);
  assign c_strb_eff = C_USE_WSTRB ? c_strb : {SW{1'b1}};

  // write FSM: collects AW and W in either order, commits on entry to W_RESP
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state      <= W_IDLE;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      REG_WE       <= '0;
      for (int i = 0; i < C_NUM_REG; i++) regs[i] <= '0;
    end else begin
      REG_WE <= '0;
      if (aw_hs) awaddr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= c_hit ? RESP_OKAY : RESP_SLVERR;
        if (c_hit) begin
          regs[c_idx]   <= merge(regs[c_idx], c_data, c_strb_eff);
          REG_WE[c_idx] <= 1'b1;
        end
      end
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) w_state <= W_RESP;
          else if (aw_hs)    w_state <= W_GOT_A;
          else if (w_hs)     w_state <= W_GOT_W;
        end
        W_GOT_A: if (w_hs)  w_state <= W_RESP;
        W_GOT_W: if (aw_hs) w_state <= W_RESP;
        W_RESP: begin
          if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  logic             r_hit;
  logic [IDX_W-1:0] r_idx;
  assign r_hit = is_hit(S_AXI_ARADDR);
  assign r_idx = to_idx(S_AXI_ARADDR);

  // read FSM: registers data/response on AR and holds them until RREADY;
  // a same-edge write commit is not visible because regs update on that edge
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state      <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RRESP  <= r_hit ? RESP_OKAY : RESP_SLVERR;
            S_AXI_RDATA  <= r_hit ? regs[r_idx] : '0;
            r_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < C_NUM_REG; i++) begin : g_out
    assign REG_OUT[DW*i +: DW] = regs[i];
  end

endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the AXI data width; only 32 is legal.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, the AXI address width.
REQ-003 The block SHALL have parameter C_BASEADDR, default 32'h70E00000, the first byte address of the block.
REQ-004 The block SHALL have parameter C_HIGHADDR, default 32'h70E0FFFF, the last byte address of the block.
REQ-005 The block SHALL have parameter C_NUM_REG, default 4, the register count; legal range 1..64.
REQ-006 The block SHALL have parameter C_USE_WSTRB, default 1; 1 applies byte-lane masking, 0 writes the full word.
REQ-007 The block SHALL use one clock and a synchronous, active-high reset: S_AXI_ACLK  in  1  clock; S_AXI_ARESET  in  1  reset.
REQ-008 The block SHALL have these AXI inputs: S_AXI_AWADDR [ADDR_W], S_AXI_AWVALID, S_AXI_WDATA [32], S_AXI_WSTRB [4], S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR [ADDR_W], S_AXI_ARVALID, S_AXI_RREADY.
REQ-009 The block SHALL have these AXI outputs: S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP [2], S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RDATA [32], S_AXI_RRESP [2], S_AXI_RVALID.
REQ-010 The block SHALL have REG_OUT  out  C_NUM_REG*32  register contents, with register i on bits [32i+31:32i].
REQ-011 The block SHALL have REG_WE  out  C_NUM_REG  a one-cycle pulse per register on a write commit.

Function
REQ-012 Address decode SHALL compute offset = addr - C_BASEADDR and index = offset[clog2(C_NUM_REG)+1:2], ignoring offset[1:0].
REQ-013 A hit SHALL be C_BASEADDR <= addr <= C_BASEADDR+4*C_NUM_REG-1; any other address SHALL be a miss with response SLVERR (2'b10); a hit SHALL respond OKAY (2'b00).
REQ-014 The write FSM SHALL have the states W_IDLE, W_GOT_A, W_GOT_W and W_RESP.
REQ-015 In W_IDLE, AWREADY and WREADY SHALL both be 1; in W_GOT_A only WREADY SHALL be 1; in W_GOT_W only AWREADY SHALL be 1; in W_RESP both SHALL be 0.
REQ-016 In W_IDLE, an AW handshake alone SHALL move to W_GOT_A with the address latched, a W handshake alone SHALL move to W_GOT_W with data and strobe latched, and both handshakes in one cycle SHALL move to W_RESP.
REQ-017 From W_GOT_A or W_GOT_W, the missing handshake SHALL move the FSM to W_RESP.
REQ-018 The write commit SHALL occur on the clock edge entering W_RESP: on a hit the register updates and REG_WE[index] pulses for exactly that one cycle; on a miss nothing updates.
REQ-019 With C_USE_WSTRB=1, byte lane b SHALL update only when WSTRB[b]=1; a WSTRB of 0 SHALL still give an OKAY response with no data change, and REG_WE SHALL still pulse.
REQ-020 BVALID SHALL be 1 throughout W_RESP with BRESP stable; on BVALID&BREADY the FSM SHALL return to W_IDLE on the next edge, and no new AW or W SHALL be accepted before then.
REQ-021 The read FSM SHALL have the states R_IDLE and R_DATA, with ARREADY=1 only in R_IDLE.
REQ-022 On an AR handshake, RDATA and RRESP SHALL be registered and RVALID SHALL be 1 on the next cycle (1-cycle latency).
REQ-023 On a read miss, RDATA SHALL be 0 and RRESP SHALL be SLVERR.
REQ-024 RDATA, RRESP and RVALID SHALL hold until RVALID&RREADY; the read FSM SHALL then return to R_IDLE, so back-to-back reads are accepted at most every 2 cycles.
REQ-025 The read and write channels SHALL be independent: a read SHALL proceed while a write is in W_GOT_A, W_GOT_W or W_RESP.
REQ-026 When an AR handshake and a write commit to the same register fall on one edge, RDATA SHALL return the pre-write value.
REQ-027 The block SHALL accept at most one outstanding transaction per channel.

Reset
REQ-028 While S_AXI_ARESET=1, the block SHALL hold AWREADY, WREADY and ARREADY at 0, even though the FSMs are in their idle states.
REQ-029 On a reset edge, the block SHALL set both FSMs to idle, all registers to 0, REG_WE to 0, BVALID and RVALID to 0, BRESP and RRESP to 2'b00, and RDATA to 0.
REQ-030 A reset mid-transaction SHALL discard the in-flight transaction with no response and no register update, even when AW/W were already latched.
REQ-031 On the first cycle after reset deasserts, AWREADY, WREADY and ARREADY SHALL be 1.

Verification
REQ-032 A bench SHALL cover: AW+W in the same cycle, addr BASE+4, data 32'hDEADBEEF, WSTRB 4'hF -> BVALID next cycle with BRESP 00, REG_WE=4'b0010 for one cycle, REG_OUT[63:32]=DEADBEEF.
REQ-033 A bench SHALL cover: W 3 cycles before AW, WSTRB 4'b0101, data 32'h11223344, over register 0=32'hFFFFFFFF -> register 0=32'hFF22FF44, with BVALID held while BREADY=0 for 5 cycles.
REQ-034 A bench SHALL cover: a read and a write of addr BASE+16 with C_NUM_REG=4 -> RRESP=10 with RDATA=0, BRESP=10, no REG_WE pulse and registers unchanged.
REQ-035 A bench SHALL cover: register 2=32'hA5A5A5A5, then an AR handshake on BASE+8 on the same edge as a write commit of 32'h0 -> RDATA=A5A5A5A5, and the next read returns 0.
REQ-036 A bench SHALL cover: reset asserted while in W_GOT_A, then a W handshake after release -> the FSM waits in W_GOT_W for a fresh AW, the old address is not written, and all registers are 0.
REQ-037 A bench SHALL cover: RREADY held 0 for 4 cycles after RVALID -> RDATA and RRESP stable and ARREADY=0 throughout.
